calc_alu: RTL and testbench

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_alu.sv | 127 ++++++++++++
 tb/tb_calc_alu.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/calc_alu.sv
// Calculator ALU: add/sub finish in one CALC cycle; mul (shift-add) and div
// (restoring) take one operand bit per cycle for 27 cycles.
module calc_alu #(
  parameter int unsigned MAX_VAL = 99_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] data1,
  input  logic [26:0] data2,
  input  logic [2:0]  arith,
  input  logic        en,
  output logic [26:0] result,
  output logic [26:0] rem,
  output logic        neg,
  output logic        err,
  output logic        done,
  output logic        busy_a
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [27:0] MAX28 = 28'(MAX_VAL);
  localparam logic [53:0] MAX54 = 54'(MAX_VAL);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [26:0] r_d1, r_d2;
  logic [4:0]  r_cnt;
  logic [53:0] r_acc, r_mcand;
  logic [26:0] r_shf;   // multiplier (mul) or dividend/quotient (div) shift register
  logic [26:0] r_rem;

  logic [27:0] w_sum;
  logic [53:0] w_acc_nxt;
  logic [27:0] w_trial;
  logic        w_ge;
  logic [26:0] w_rem_nxt, w_quo_nxt;
  logic        w_iter, w_last;

  assign w_sum     = {1'b0, r_d1} + {1'b0, r_d2};
  assign w_acc_nxt = r_shf[0] ? r_acc + r_mcand : r_acc;
  assign w_trial   = {r_rem, r_shf[26]};
  assign w_ge      = w_trial >= {1'b0, r_d2};
  assign w_rem_nxt = w_ge ? w_trial[26:0] - r_d2 : w_trial[26:0];
  assign w_quo_nxt = {r_shf[25:0], w_ge};
  assign w_iter    = (r_op == 3'b010) || (r_op == 3'b011);
  assign w_last    = !w_iter || (r_cnt == 5'd26);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_shf   <= '0;
      r_rem   <= '0;
      result  <= '0;
      rem     <= '0;
      neg     <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy_a  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (en) begin
          r_op    <= arith;
          r_d1    <= data1;
          r_d2    <= data2;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_rem   <= '0;
          r_mcand <= {27'd0, data1};
          r_shf   <= (arith == 3'b011) ? data1 : data2;
          busy_a  <= 1'b1;
          r_state <= CALC;
        end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op == 3'b010) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_shf   <= r_shf >> 1;
          end else if (r_op == 3'b011) begin
            r_rem <= w_rem_nxt;
            r_shf <= w_quo_nxt;
          end
          if (w_last) begin
            r_state <= DONE;
            busy_a  <= 1'b0;
            done    <= 1'b1;
            rem     <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            case (r_op)
              3'b000: begin
                err    <= w_sum > MAX28;
                result <= (w_sum > MAX28) ? 27'd0 : w_sum[26:0];
              end
              3'b001: begin
                neg    <= r_d1 < r_d2;
                result <= (r_d1 >= r_d2) ? r_d1 - r_d2 : r_d2 - r_d1;
              end
              3'b010: begin
                err    <= w_acc_nxt > MAX54;
                result <= (w_acc_nxt > MAX54) ? 27'd0 : w_acc_nxt[26:0];
              end
              3'b011: begin
                err    <= r_d2 == 27'd0;
                result <= (r_d2 == 27'd0) ? 27'd0 : w_quo_nxt;
                rem    <= (r_d2 == 27'd0) ? 27'd0 : w_rem_nxt;
              end
              default: begin
                err    <= 1'b1;
                result <= '0;
              end
            endcase
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu: a behavioural model pushes expected results
// when a request is driven; they are popped and compared on the done pulse.
module tb_calc_alu;
  localparam longint unsigned MAXV = 99_999_999;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [26:0] data1 = '0, data2 = '0;
  logic [2:0]  arith = '0;
  logic [26:0] result, rem;
  logic        neg, err, done, busy_a;

  calc_alu dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2), .arith(arith),
    .en(en), .result(result), .rem(rem), .neg(neg), .err(err),
    .done(done), .busy_a(busy_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned res;
    longint unsigned rm;
    bit              ng;
    bit              er;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int   errs = 0, checks = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(longint unsigned a, longint unsigned b, int op);
    exp_t e;
    longint unsigned v;
    e = '{res: 0, rm: 0, ng: 0, er: 0, lat: 1};
    case (op)
      0: begin v = a + b; if (v > MAXV) e.er = 1; else e.res = v; end
      1: begin
        if (a >= b) e.res = a - b;
        else begin e.res = b - a; e.ng = 1; end
      end
      2: begin v = a * b; e.lat = 27; if (v > MAXV) e.er = 1; else e.res = v; end
      3: begin
        e.lat = 27;
        if (b == 0) e.er = 1;
        else begin e.res = a / b; e.rm = a % b; end
      end
      default: e.er = 1;
    endcase
    return e;
  endfunction

  // Waits for done after an accepted request; optionally pokes en mid-operation.
  task automatic wait_check(input bit poke);
    exp_t e;
    int   n, bsy, extra;
    bit   seen;
    bsy = busy_a; n = 0; seen = 0;
    while (!seen && n < 40) begin
      if (poke && n == 5) begin
        @(negedge clk); en = 1; data1 = 27'd1; data2 = 27'd1; arith = 3'd0;
      end
      @(posedge clk); #1;
      en = 0; n++;
      if (done) seen = 1; else bsy += int'(busy_a);
    end
    chk("done_seen", longint'(seen), 1);
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("busy_cycles", bsy, e.lat);
    chk("busy_at_done", busy_a, 0);
    chk("result", result, e.res);
    chk("rem", rem, e.rm);
    chk("neg", neg, e.ng);
    chk("err", err, e.er);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("result_hold", result, e.res);
    if (poke) begin
      extra = 0;
      repeat (35) begin @(posedge clk); #1; if (done) extra++; end
      chk("poke_no_extra_done", extra, 0);
    end
  endtask

  task automatic run(input logic [26:0] a, input logic [26:0] b, input logic [2:0] op, input bit poke);
    sb.push_back(model(a, b, op));
    @(negedge clk); data1 = a; data2 = b; arith = op; en = 1;
    @(posedge clk); #1;
    en = 0;
    data1 = 27'($urandom); data2 = 27'($urandom); arith = 3'($urandom);
    chk("busy_after_accept", busy_a, 1);
    wait_check(poke);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_rem", rem, 0);
    chk("rst_flags", {neg, err, done, busy_a}, 0);
    @(negedge clk); rst = 0;

    run(27'd99_999_990, 27'd9, 3'd0, 0);
    run(27'd99_999_990, 27'd10, 3'd0, 0);
    run(27'd5, 27'd12, 3'd1, 0);
    run(27'd3, 27'd3, 3'd1, 0);
    run(27'd12_345, 27'd8_100, 3'd2, 0);
    run(27'd10_000, 27'd10_000, 3'd2, 0);
    run(27'd100, 27'd7, 3'd3, 0);
    run(27'd100, 27'd0, 3'd3, 0);
    run(27'd0, 27'd55, 3'd3, 0);
    run(27'd0, 27'd55, 3'd2, 0);
    run(27'd0, 27'd55, 3'd0, 0);
    run(27'd123, 27'd456, 3'd5, 0);
    run(27'd1, 27'd2, 3'd0, 0);
    run(27'h7FF_FFFF, 27'd1, 3'd3, 0);
    run(27'd321, 27'd3, 3'd2, 1);
    for (int i = 0; i < 8; i++)
      run(27'($urandom_range(0, 20000)), 27'($urandom_range(0, 20000)),
          3'($urandom_range(0, 3)), 0);

    // Abort a multiply at CALC cycle 10, with en held high through reset.
    @(negedge clk); data1 = 27'd1000; data2 = 27'd1000; arith = 3'd2; en = 1;
    @(posedge clk); #1; en = 0;
    repeat (9) begin @(posedge clk); #1; chk("no_done_pre_abort", done, 0); end
    @(negedge clk); rst = 1; en = 1; data1 = 27'd5; data2 = 27'd6; arith = 3'd0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_result", result, 0);
      chk("abort_flags", {rem, neg, err, done, busy_a}, 0);
    end
    sb.push_back(model(5, 6, 0));
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("accept_after_rst", busy_a, 1);
    en = 0;
    wait_check(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
